// File: rtl/tone_voice_scheduler_if.sv
// Host/config and tone-generator signals of tone_voice_scheduler.
// The master side drives the writes and the generator output, and the slave side is the scheduler.
interface tone_voice_scheduler_if #(
   parameter int VOICES = 4
);
   localparam int VS_W = $clog2(VOICES);

   logic            sample_tick;
   logic            wr_en;
   logic [VS_W-1:0] wr_voice;
   logic [23:0]     wr_freq;
   logic            wr_gate;
   logic            wr_phase_clr;
   logic [23:0]     tri_acc;
   logic [15:0]     tri_dout;
   logic [15:0]     sample_out;
   logic            sample_valid;
   logic            busy;
   logic            overrun;

   modport master (
      output sample_tick, wr_en, wr_voice, wr_freq, wr_gate, wr_phase_clr, tri_dout,
      input  tri_acc, sample_out, sample_valid, busy, overrun
   );

   modport slave (
      input  sample_tick, wr_en, wr_voice, wr_freq, wr_gate, wr_phase_clr, tri_dout,
      output tri_acc, sample_out, sample_valid, busy, overrun
   );
endinterface

// File: rtl/tone_voice_scheduler.sv
// Time-multiplexes one combinational triangle generator across VOICES phase accumulators.
// Optional per-voice gating is enabled with the TONE_SCHED_GATE_EN macro.
module tone_voice_scheduler #(
   parameter int VOICES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   tone_voice_scheduler_if.slave   bus
);
   localparam int VS_W  = $clog2(VOICES);
   localparam int SUM_W = 16 + VS_W;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [VS_W-1:0]   vidx_q, vidx_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [SUM_W-1:0]  sum_next;
   logic [23:0]       acc_q [VOICES];
   logic [23:0]       acc_d [VOICES];
   logic [23:0]       freq_q [VOICES];
   logic [23:0]       freq_d [VOICES];
   logic [15:0]       sample_out_q, sample_out_d;
   logic              sample_valid_q, sample_valid_d;
   logic              overrun_q, overrun_d;
   logic              voice_active;

`ifdef TONE_SCHED_GATE_EN
   logic [VOICES-1:0] gate_q, gate_d;
   assign voice_active = gate_q[vidx_q];
`else
   logic unused_wr_gate;
   assign unused_wr_gate = bus.wr_gate;
   assign voice_active   = 1'b1;
`endif

   assign bus.tri_acc      = (state_q == RUN) ? acc_q[vidx_q] : acc_q[0];
   assign bus.sample_out   = sample_out_q;
   assign bus.sample_valid = sample_valid_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.overrun      = overrun_q;

   // Frame sequencing first, then host writes so a phase clear overrides the increment.
   always_comb begin
      state_d        = state_q;
      vidx_d         = vidx_q;
      sum_d          = sum_q;
      acc_d          = acc_q;
      freq_d         = freq_q;
      sample_out_d   = sample_out_q;
      sample_valid_d = 1'b0;
      overrun_d      = overrun_q;
`ifdef TONE_SCHED_GATE_EN
      gate_d         = gate_q;
`endif
      sum_next = voice_active ? (sum_q + {{VS_W{1'b0}}, bus.tri_dout}) : sum_q;

      case (state_q)
         IDLE: begin
            if (bus.sample_tick) begin
               vidx_d  = '0;
               sum_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.sample_tick) overrun_d = 1'b1;
            sum_d = sum_next;
            if (voice_active) acc_d[vidx_q] = acc_q[vidx_q] + freq_q[vidx_q];
            vidx_d = vidx_q + VS_W'(1);
            if (vidx_q == VS_W'(VOICES - 1)) begin
               state_d        = DONE;
               sample_out_d   = sum_next[SUM_W-1:VS_W];
               sample_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (bus.sample_tick) overrun_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (bus.wr_en) begin
         freq_d[bus.wr_voice] = bus.wr_freq;
`ifdef TONE_SCHED_GATE_EN
         gate_d[bus.wr_voice] = bus.wr_gate;
`endif
         if (bus.wr_phase_clr) acc_d[bus.wr_voice] = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         vidx_q         <= '0;
         sum_q          <= '0;
         acc_q          <= '{default: '0};
         freq_q         <= '{default: '0};
         sample_out_q   <= '0;
         sample_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
`ifdef TONE_SCHED_GATE_EN
         gate_q         <= '0;
`endif
      end else begin
         state_q        <= state_d;
         vidx_q         <= vidx_d;
         sum_q          <= sum_d;
         acc_q          <= acc_d;
         freq_q         <= freq_d;
         sample_out_q   <= sample_out_d;
         sample_valid_q <= sample_valid_d;
         overrun_q      <= overrun_d;
`ifdef TONE_SCHED_GATE_EN
         gate_q         <= gate_d;
`endif
      end
   end
endmodule

// File: tb/tb_tone_voice_scheduler.sv
// Self-checking bench for tone_voice_scheduler: directed frames plus randomized writes,
// compared against a per-voice arithmetic model of the accumulators and the mixed sample.
module tb_tone_voice_scheduler;
   localparam int VOICES = 4;
   localparam int VS_W   = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tone_voice_scheduler_if #(.VOICES(VOICES)) bus ();
   tone_voice_scheduler #(.VOICES(VOICES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // Triangle generator: rising over the first half of the phase, falling over the second.
   function automatic logic [15:0] tri_gen(input logic [23:0] a);
      return a[23] ? ~a[22:7] : a[22:7];
   endfunction

   assign bus.tri_dout = tri_gen(bus.tri_acc);

   int          compared   = 0;
   int          mismatched = 0;
   logic [23:0] m_acc  [VOICES];
   logic [23:0] m_freq [VOICES];
   logic        m_gate [VOICES];
   logic        m_overrun;

   function automatic bit voice_on(input int v);
`ifdef TONE_SCHED_GATE_EN
      return m_gate[v];
`else
      return (v >= 0);
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int v = 0; v < VOICES; v++) begin
         m_acc[v]  = '0;
         m_freq[v] = '0;
         m_gate[v] = 1'b0;
      end
      m_overrun = 1'b0;
   endtask

   task automatic model_write(input int v, input logic [23:0] f, input logic g, input logic clr);
      m_freq[v] = f;
      m_gate[v] = g;
      if (clr) m_acc[v] = '0;
   endtask

   task automatic applyStimulus(input int v, input logic [23:0] f, input logic g, input logic clr);
      bus.wr_en        = 1'b1;
      bus.wr_voice     = VS_W'(v);
      bus.wr_freq      = f;
      bus.wr_gate      = g;
      bus.wr_phase_clr = clr;
      step();
      bus.wr_en        = 1'b0;
      bus.wr_phase_clr = 1'b0;
      model_write(v, f, g, clr);
   endtask

   // One full frame; optional extra tick and/or host write during a chosen RUN slot.
   task automatic runFrame(input int tick_slot, input int wr_slot, input int wr_v,
                           input logic [23:0] wr_f, input logic wr_g, input logic wr_clr);
      int          total;
      logic [15:0] exp_out;
      total = 0;
      bus.sample_tick = 1'b1;
      step();
      bus.sample_tick = 1'b0;
      for (int s = 0; s < VOICES; s++) begin
         checkOutput("busy_run", 32'(bus.busy), 32'd1);
         checkOutput($sformatf("tri_acc_slot%0d", s), 32'(bus.tri_acc), 32'(m_acc[s]));
         bus.sample_tick = (s == tick_slot);
         if (s == wr_slot) begin
            bus.wr_en        = 1'b1;
            bus.wr_voice     = VS_W'(wr_v);
            bus.wr_freq      = wr_f;
            bus.wr_gate      = wr_g;
            bus.wr_phase_clr = wr_clr;
         end
         step();
         bus.sample_tick  = 1'b0;
         bus.wr_en        = 1'b0;
         bus.wr_phase_clr = 1'b0;
         if (voice_on(s)) begin
            total    += int'(tri_gen(m_acc[s]));
            m_acc[s] = m_acc[s] + m_freq[s];
         end
         if (s == wr_slot) model_write(wr_v, wr_f, wr_g, wr_clr);
      end
      if (tick_slot >= 0) m_overrun = 1'b1;
      exp_out = 16'(total / VOICES);
      checkOutput("sample_valid", 32'(bus.sample_valid), 32'd1);
      checkOutput("sample_out", 32'(bus.sample_out), 32'(exp_out));
      checkOutput("busy_done", 32'(bus.busy), 32'd1);
      step();
      checkOutput("valid_drop", 32'(bus.sample_valid), 32'd0);
      checkOutput("busy_idle", 32'(bus.busy), 32'd0);
      checkOutput("overrun", 32'(bus.overrun), 32'(m_overrun));
   endtask

   initial begin
      bus.sample_tick  = 1'b0;
      bus.wr_en        = 1'b0;
      bus.wr_voice     = '0;
      bus.wr_freq      = '0;
      bus.wr_gate      = 1'b0;
      bus.wr_phase_clr = 1'b0;
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_sample_out", 32'(bus.sample_out), 32'd0);
      checkOutput("rst_valid", 32'(bus.sample_valid), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_overrun", 32'(bus.overrun), 32'd0);
      checkOutput("rst_tri_acc", 32'(bus.tri_acc), 32'd0);
      rst_n = 1'b1;
      step();

      $display("[TB] silent frame");
      runFrame(-1, -1, 0, '0, 1'b0, 1'b0);

      $display("[TB] voice 0 phase sweep and wrap");
      applyStimulus(0, 24'h100000, 1'b1, 1'b0);
      for (int f = 0; f < 16; f++) runFrame(-1, -1, 0, '0, 1'b0, 1'b0);
      checkOutput("acc0_wrapped", 32'(bus.tri_acc), 32'd0);

      $display("[TB] full-scale mix");
      for (int v = 0; v < VOICES; v++) applyStimulus(v, 24'h7FFF80, 1'b1, 1'b1);
      runFrame(-1, -1, 0, '0, 1'b0, 1'b0);
      runFrame(-1, -1, 0, '0, 1'b0, 1'b0);
      checkOutput("full_scale", 32'(bus.sample_out), 32'h0000FFFF);

      $display("[TB] tick while busy");
      runFrame(1, -1, 0, '0, 1'b0, 1'b0);
      repeat (6) begin
         checkOutput("no_extra_valid", 32'(bus.sample_valid), 32'd0);
         step();
      end
      runFrame(-1, -1, 0, '0, 1'b0, 1'b0);
      runFrame(-1, -1, 0, '0, 1'b0, 1'b0);

      $display("[TB] phase clear during own slot");
      applyStimulus(0, 24'h010203, 1'b1, 1'b0);
      applyStimulus(1, 24'h0A0B0C, 1'b1, 1'b0);
      applyStimulus(2, 24'h123456, 1'b1, 1'b0);
      applyStimulus(3, 24'h300001, 1'b1, 1'b0);
      runFrame(-1, -1, 0, '0, 1'b0, 1'b0);
      runFrame(-1, 2, 2, 24'h012345, 1'b1, 1'b1);
      checkOutput("acc2_cleared_model", 32'(m_acc[2]), 32'd0);
      runFrame(-1, -1, 0, '0, 1'b0, 1'b0);

      $display("[TB] gate voice 1 off");
      applyStimulus(1, 24'h020000, 1'b0, 1'b0);
      runFrame(-1, -1, 0, '0, 1'b0, 1'b0);
      runFrame(-1, -1, 0, '0, 1'b0, 1'b0);

      $display("[TB] reset mid-frame");
      bus.sample_tick = 1'b1;
      step();
      bus.sample_tick = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      model_reset();
      checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
      checkOutput("midrst_tri_acc", 32'(bus.tri_acc), 32'd0);
      checkOutput("midrst_overrun", 32'(bus.overrun), 32'd0);
      #1;
      rst_n = 1'b1;
      repeat (VOICES + 2) begin
         step();
         checkOutput("midrst_no_valid", 32'(bus.sample_valid), 32'd0);
      end

      $display("[TB] randomized frames");
      for (int f = 0; f < 24; f++) begin
         int n_wr;
         n_wr = int'($urandom_range(0, 2));
         for (int w = 0; w < n_wr; w++)
            applyStimulus(int'($urandom_range(0, VOICES - 1)), 24'($urandom),
                          1'($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
         runFrame(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, VOICES - 1)) : -1,
                  int'($urandom_range(0, VOICES)) - 1,
                  int'($urandom_range(0, VOICES - 1)), 24'($urandom),
                  1'($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
